// File: rtl/fp16_pkg.sv
// Shared binary16 constants and field layout for the half-precision datapath.
package fp16_pkg;

  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam int FP16_BIAS  = 15;

  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam logic [15:0] FP16_PINF = 16'h7C00;

  typedef struct packed {
    logic                  sign;
    logic [FP16_EXP_W-1:0] exp;
    logic [FP16_MAN_W-1:0] man;
  } fp16_t;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter. An all-zero input reports WIDTH.
module fp_lzc #(
  parameter int WIDTH = 14,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_bits,
  output logic [CNT_W-1:0] count
);

  // Scan from the MSB down and keep the first set bit found.
  always_comb begin
    logic found;
    found = 1'b0;
    count = CNT_W'(WIDTH);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && in_bits[i]) begin
        count = CNT_W'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/floating_point_adder.sv
// Single-cycle binary16 adder: align, add/sub, normalize, round-to-nearest-even,
// special-value handling, then one output register gated by en.
module floating_point_adder
  import fp16_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result
);

  fp16_t       fa, fb, fx, fy;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [10:0] sig_x, sig_y;
  logic [4:0]  ex, ey, diff;
  logic [23:0] y_wide;
  logic [12:0] y_al;
  logic        sticky;
  logic [13:0] s;
  logic [3:0]  lz;
  logic [5:0]  want, lim, shamt, e_n, e_out;
  logic [12:0] n;
  logic        sticky_n, round_up;
  logic [11:0] m;
  logic [9:0]  man_out;
  logic [15:0] sum_val;
  logic [15:0] result_d, result_q;

  assign fa = fp16_t'(a);
  assign fb = fp16_t'(b);

  // Unpack, order by magnitude, align the smaller operand and add or subtract.
  always_comb begin
    a_nan = (fa.exp == 5'h1F) && (fa.man != '0);
    b_nan = (fb.exp == 5'h1F) && (fb.man != '0);
    a_inf = (fa.exp == 5'h1F) && (fa.man == '0);
    b_inf = (fb.exp == 5'h1F) && (fb.man == '0);
    if (fb[14:0] > fa[14:0]) begin
      fx = fb;
      fy = fa;
    end else begin
      fx = fa;
      fy = fb;
    end
    sig_x  = {(fx.exp != '0), fx.man};
    sig_y  = {(fy.exp != '0), fy.man};
    ex     = (fx.exp == '0) ? 5'd1 : fx.exp;
    ey     = (fy.exp == '0) ? 5'd1 : fy.exp;
    diff   = ex - ey;
    // The 13-bit window holds significand, guard and round; the rest is sticky.
    y_wide = {sig_y, 13'b0} >> diff;
    y_al   = y_wide[23:11];
    sticky = (diff >= 5'd14) ? (|sig_y) : (|y_wide[10:0]);
    if (fx.sign == fy.sign) begin
      s = {1'b0, sig_x, 2'b00} + {1'b0, y_al};
    end else begin
      // Borrow the sticky fraction so the kept bits are the truncated difference.
      s = {1'b0, sig_x, 2'b00} - {1'b0, y_al} - {13'b0, sticky};
    end
  end

  fp_lzc #(.WIDTH(14)) u_lzc (
    .in_bits(s),
    .count  (lz)
  );

  // Normalize, round to nearest even and select special-case results.
  always_comb begin
    want     = {2'b00, lz} - 6'd1;
    lim      = {1'b0, ex} - 6'd1;
    shamt    = 6'd0;
    n        = s[12:0];
    sticky_n = sticky;
    e_n      = {1'b0, ex};
    if (s[13]) begin
      n        = s[13:1];
      sticky_n = sticky | s[0];
      e_n      = {1'b0, ex} + 6'd1;
    end else begin
      // Stop at effective exponent 1 so tiny results stay subnormal.
      shamt = (want < lim) ? want : lim;
      n     = s[12:0] << shamt;
      e_n   = {1'b0, ex} - shamt;
    end
    round_up = n[1] & (n[0] | sticky_n | n[2]);
    m        = {1'b0, n[12:2]} + {11'b0, round_up};
    if (m[11]) begin
      e_out   = e_n + 6'd1;
      man_out = m[10:1];
    end else begin
      e_out   = m[10] ? e_n : 6'd0;
      man_out = m[9:0];
    end

    if (a_nan || b_nan || (a_inf && b_inf && (fa.sign != fb.sign))) begin
      sum_val = FP16_QNAN;
    end else if (a_inf) begin
      sum_val = fa;
    end else if (b_inf) begin
      sum_val = fb;
    end else if ((s == '0) && !sticky) begin
      // Only two negative zeros give -0; every other exact zero is +0.
      sum_val = {fa.sign & fb.sign, 15'b0};
    end else if (e_out >= 6'd31) begin
      sum_val = {fx.sign, FP16_PINF[14:0]};
    end else begin
      sum_val = {fx.sign, e_out[4:0], man_out};
    end

    result_d = en ? sum_val : result_q;
  end

  // Output register; reset wins over en.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_floating_point_adder.sv
// Directed-vector bench for floating_point_adder with a queue-based scoreboard.
module tb_floating_point_adder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [15:0] result;

  logic [15:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          failures = 0;

  floating_point_adder #(.DATA_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .a     (a),
    .b     (b),
    .result(result)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the value expected after the next edge.
  task automatic step(input logic r, input logic e, input logic [15:0] va,
                      input logic [15:0] vb, input logic [15:0] expv, input string nm);
    @(negedge clk);
    reset = r;
    en    = e;
    a     = va;
    b     = vb;
    exp_q.push_back(expv);
    name_q.push_back(nm);
  endtask

  // Monitor: after each rising edge, compare against the oldest queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [15:0] ev;
        string       nm;
        ev = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (result !== ev) begin
          failures++;
          $display("FAIL %s: result=%h expected=%h", nm, result, ev);
        end else begin
          $display("ok   %s: result=%h", nm, result);
        end
      end
    end
  end

  initial begin
    step(1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, "reset");
    step(1'b0, 1'b1, 16'h4200, 16'hC600, 16'hC200, "3-6");
    step(1'b0, 1'b1, 16'h3C00, 16'h3C00, 16'h4000, "1+1");
    step(1'b0, 1'b1, 16'h3C00, 16'hBC00, 16'h0000, "cancel");
    step(1'b0, 1'b0, 16'h1234, 16'h5678, 16'h0000, "hold0");
    step(1'b0, 1'b0, 16'h4000, 16'h4000, 16'h0000, "hold1");
    step(1'b0, 1'b1, 16'h3C00, 16'h1000, 16'h3C00, "tie_even");
    step(1'b0, 1'b1, 16'h3C01, 16'h1000, 16'h3C02, "tie_up");
    step(1'b0, 1'b1, 16'h3C00, 16'h0C00, 16'h3C00, "below_half");
    step(1'b0, 1'b1, 16'h3C00, 16'h1400, 16'h3C01, "one_ulp");
    step(1'b0, 1'b1, 16'h3C00, 16'h1001, 16'h3C01, "above_half");
    step(1'b0, 1'b1, 16'h7BFF, 16'h7BFF, 16'h7C00, "overflow");
    step(1'b0, 1'b1, 16'h0001, 16'h0001, 16'h0002, "sub+sub");
    step(1'b0, 1'b1, 16'h03FF, 16'h0001, 16'h0400, "sub_to_norm");
    step(1'b0, 1'b1, 16'h7C00, 16'hFC00, 16'h7E00, "inf-inf");
    step(1'b0, 1'b1, 16'h7E01, 16'h3C00, 16'h7E00, "nan_in");
    step(1'b0, 1'b1, 16'hFC00, 16'h4200, 16'hFC00, "ninf+fin");
    step(1'b0, 1'b1, 16'h8000, 16'h8000, 16'h8000, "-0+-0");
    step(1'b0, 1'b1, 16'h0000, 16'h8000, 16'h0000, "+0+-0");
    step(1'b0, 1'b1, 16'h3C00, 16'hC000, 16'hBC00, "1-2");
    step(1'b0, 1'b1, 16'h4400, 16'h3C00, 16'h4500, "4+1");
    step(1'b0, 1'b1, 16'h4000, 16'h4000, 16'h4400, "2+2");
    step(1'b0, 1'b1, 16'h4200, 16'h3C00, 16'h4400, "3+1");
    step(1'b0, 1'b1, 16'h3800, 16'h3800, 16'h3C00, "half+half");
    step(1'b1, 1'b1, 16'h4000, 16'h4000, 16'h0000, "reset_prio");
    step(1'b0, 1'b1, 16'h3C00, 16'h0000, 16'h3C00, "1+0");
    step(1'b0, 1'b1, 16'h7C00, 16'h3C00, 16'h7C00, "pinf+fin");
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h7C00, "hold_inf");

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
